// File: rtl/uart_pkg.sv
// Shared UART types and baud arithmetic, so the transmit and receive halves derive identical bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Truncating division; widened so large clock rates do not overflow before the divide.
    function automatic int clks_per_bit(input int clk_khz, input int bods);
        longint num;
        num = longint'(clk_khz) * 64'sd1000;
        return int'(num / longint'(bods));
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: tick_o marks the last clock of each bit period while run_i is high.
// Combinational tick from a registered count; no flow control, run_i=0 clears the count.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic tick_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_rate
            $error("uart_bit_timer: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    logic [CW-1:0] count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (!run_i || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick_o = run_i && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_AMOUNT bits LSB first, odd parity, one stop; (DATA_AMOUNT+3) bit periods per frame.
// Registered txd_o/ready_o; a word is accepted only while ready_o=1, inputs are ignored mid-frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_KHZ     = 100000,
    parameter int BODS        = 9600,
    parameter int DATA_AMOUNT = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [DATA_AMOUNT-1:0] data_i,
    output logic                   txd_o,
    output logic                   ready_o
);

    localparam int CPB = clks_per_bit(CLK_KHZ, BODS);
    localparam int IW  = $clog2(DATA_AMOUNT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_AMOUNT - 1);

    generate
        if (DATA_AMOUNT < 1 || DATA_AMOUNT > 16) begin : g_bad_width
            $error("uart_tx: DATA_AMOUNT must be within 1..16");
        end
    endgenerate

    uart_state_t            state;
    logic [DATA_AMOUNT-1:0] shreg;
    logic [DATA_AMOUNT-1:0] sh_next;
    logic [IW-1:0]          idx;
    logic                   par;
    logic                   tick;

    assign sh_next = shreg >> 1;

    uart_bit_timer #(
        .CLKS_PER_BIT(CPB)
    ) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .run_i (state != IDLE),
        .tick_o(tick)
    );

    // txd_o is loaded with the level of the state being entered, so the line stays registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            shreg   <= '0;
            idx     <= '0;
            par     <= 1'b0;
            txd_o   <= 1'b1;
            ready_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd_o   <= 1'b1;
                    ready_o <= 1'b1;
                    if (en_i) begin
                        shreg   <= data_i;
                        par     <= ~^data_i;
                        idx     <= '0;
                        state   <= START;
                        txd_o   <= 1'b0;
                        ready_o <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        txd_o <= shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= sh_next;
                        idx   <= idx + IW'(1);
                        if (idx == LAST_IDX) begin
                            state <= PARITY;
                            txd_o <= par;
                        end else begin
                            txd_o <= sh_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        txd_o <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                        txd_o   <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd_o   <= 1'b1;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at 10 clocks per bit: frame-level reference model, literal frame vectors, serial receiver loopback.
module tb_uart_tx;

    localparam int N     = 10;
    localparam int FRAME = 11 * N;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] data = 8'h00;
    logic       txd;
    logic       ready;

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    uart_tx #(
        .CLK_KHZ    (1000),
        .BODS       (100000),
        .DATA_AMOUNT(8)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .data_i (data),
        .txd_o  (txd),
        .ready_o(ready)
    );

    always #5 clk = ~clk;

    // Level of bit k of the frame carrying word w.
    function automatic logic frame_bit(input logic [7:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return w[k-1];
        if (k == 9) return ($countones(w) % 2 == 0);
        return 1'b1;
    endfunction

    // Reference: a frame occupies FRAME clocks after the accepting edge, then one idle edge.
    logic       m_busy;
    int         m_t;
    logic [7:0] m_word;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_t    <= 0;
        end else if (!m_busy) begin
            if (en) begin
                m_busy <= 1'b1;
                m_t    <= 0;
                m_word <= data;
            end
        end else if (m_t == FRAME - 1) begin
            m_busy <= 1'b0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    logic exp_txd;
    logic exp_ready;
    assign exp_ready = !m_busy;
    assign exp_txd   = m_busy ? frame_bit(m_word, m_t / N) : 1'b1;

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (txd !== exp_txd || ready !== exp_ready) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t txd=%b ready=%b required txd=%b ready=%b",
                         $time, txd, ready, exp_txd, exp_ready);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sends one word, samples each bit mid-period and measures how long ready stays low.
    task automatic run_frame(input logic [7:0] w, input int chg_at, input logic [7:0] w2,
                             output logic [10:0] bits, output int low);
        bits = '0;
        low  = -1;
        @(negedge clk);
        en   = 1'b1;
        data = w;
        @(negedge clk);
        en = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (t > 0) @(negedge clk);
            if (t == chg_at) data = w2;
            if (ready) begin
                low = t;
                break;
            end
            if (t % N == 5 && t < FRAME) bits[t/N] = txd;
        end
        if (low < 0) chk("frame_timeout", 32'd1, 32'd0);
    endtask

    // Independent serial receiver: finds a start bit, samples mid-bit, checks parity and stop.
    task automatic rx_frame(output logic [7:0] w, output logic ok);
        logic found, st, p, sp;
        found = 1'b0;
        ok    = 1'b0;
        w     = '0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (txd == 1'b0) found = 1'b1;
        end
        if (!found) begin
            chk("rx_timeout", 32'd1, 32'd0);
        end else begin
            repeat (5) @(negedge clk);
            st = txd;
            for (int i = 0; i < 8; i++) begin
                repeat (N) @(negedge clk);
                w[i] = txd;
            end
            repeat (N) @(negedge clk);
            p = txd;
            repeat (N) @(negedge clk);
            sp = txd;
            ok = (st == 1'b0) && (sp == 1'b1) && ($countones({w, p}) % 2 == 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits, bits2;
        int          low, low2;
        logic [7:0]  rw0, rw1;
        logic        ok0, ok1;

        // Reset held with a pending request: line stays idle.
        #1;
        rst  = 1'b1;
        en   = 1'b1;
        data = 8'h55;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        en  = 1'b0;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_idle_txd", 32'(txd), 32'd1);
        chk("post_rst_idle_ready", 32'(ready), 32'd1);

        run_frame(8'h72, -1, 8'h00, bits, low);
        chk("x72_bits", 32'(bits), 32'(11'b11011100100));
        chk("x72_ready_low", 32'(low), 32'd110);

        run_frame(8'hA1, 30, 8'hFF, bits, low);
        chk("xA1_bits", 32'(bits), 32'(11'b10101000010));
        chk("xA1_ready_low", 32'(low), 32'd110);

        // Back-to-back with en held high; data switches during frame 1.
        bits  = '0;
        bits2 = '0;
        @(negedge clk);
        en   = 1'b1;
        data = 8'h08;
        for (int t = 0; t <= 221; t++) begin
            @(negedge clk);
            if (t == 40) data = 8'h7F;
            if (t == 111) en = 1'b0;
            if (t < FRAME && t % N == 5) bits[t/N] = txd;
            if (t >= 111 && t < 111 + FRAME && (t - 111) % N == 5) bits2[(t-111)/N] = txd;
            if (t == 109) chk("b2b_busy_end", 32'(ready), 32'd0);
            if (t == 110) begin
                chk("b2b_gap_ready", 32'(ready), 32'd1);
                chk("b2b_gap_txd", 32'(txd), 32'd1);
            end
            if (t == 111) begin
                chk("b2b_f2_ready", 32'(ready), 32'd0);
                chk("b2b_f2_start", 32'(txd), 32'd0);
            end
            if (t == 221) chk("b2b_f2_done", 32'(ready), 32'd1);
        end
        chk("b2b_f1_bits", 32'(bits), 32'(11'b10000010000));
        chk("b2b_f2_bits", 32'(bits2), 32'(11'b10011111110));

        // Reset pulse during data bit 4 of 0xA1 (a 0 bit), then a clean frame.
        @(negedge clk);
        en   = 1'b1;
        data = 8'hA1;
        @(negedge clk);
        en = 1'b0;
        repeat (55) @(negedge clk);
        chk("mid_d4_before_rst", 32'(txd), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        #1 rst = 1'b0;
        run_frame(8'h08, -1, 8'h00, bits, low);
        chk("after_rst_bits", 32'(bits), 32'(11'b10000010000));
        chk("after_rst_ready_low", 32'(low), 32'd110);

        // Loopback into a serial receiver.
        fork
            begin
                run_frame(8'h72, -1, 8'h00, bits, low);
                run_frame(8'hA1, -1, 8'h00, bits2, low2);
            end
            begin
                rx_frame(rw0, ok0);
                rx_frame(rw1, ok1);
            end
        join
        chk("loop_rx0_ok", 32'(ok0), 32'd1);
        chk("loop_rx0_data", 32'(rw0), 32'h72);
        chk("loop_rx1_ok", 32'(ok1), 32'd1);
        chk("loop_rx1_data", 32'(rw1), 32'hA1);

        repeat (5) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Standalone UART transmitter: accepts a `DATA_AMOUNT`-bit word through a ready/enable handshake and serializes it on `txd_o`. The frame is a start bit, the data bits LSB first, an odd parity bit and one stop bit. It is the transmit half of `top_uart` and is bit-compatible with the project's UART receiver, so `txd_o` can loop back into `rxd_i`.

## Interface
- `CLK_KHZ`, default 100000: system clock frequency in kHz.
- `BODS`, default 9600: baud rate in bit/s.
- `DATA_AMOUNT`, default 8: data bits per frame (1..16).
- `clk_i`  in  1: system clock; all logic on the rising edge.
- `rst_i`  in  1: reset. Asynchronous, active-high.
- `en_i`  in  1: transmit request. Sampled only while `ready_o`=1.
- `data_i`  in  `DATA_AMOUNT`: word to send. Captured on the accepting edge.
- `txd_o`  out  1: serial line. Idles high. Registered.
- `ready_o`  out  1: idle and able to accept. Registered.

## Operation
- Derived constant: `CLKS_PER_BIT = (CLK_KHZ*1000)/BODS`, truncating integer division. The defaults give 10416. `CLKS_PER_BIT` < 2 is an elaboration error.
- FSM states and transitions:
  - `IDLE` → `START` when `en_i`=1.
  - `START` → `DATA` on a bit tick.
  - `DATA` → `PARITY` on the tick that ends bit `DATA_AMOUNT-1`.
  - `PARITY` → `STOP` on a bit tick.
  - `STOP` → `IDLE` on a bit tick.
- `txd_o` by state:
  - `IDLE`: 1.
  - `START`: 0.
  - `DATA`: `shreg[0]`.
  - `PARITY`: `~^data`, odd parity, so the data plus parity bits contain an odd number of ones.
  - `STOP`: 1.
- On acceptance:
  - Latch `data_i` into the shift register.
  - Compute and store the parity from `data_i`.
  - Clear the bit timer and the bit index.
- In `DATA`, each tick shifts the register right by one and increments the bit index. The index width is `$clog2(DATA_AMOUNT+1)`.
- Bit timer:
  - Counts 0..`CLKS_PER_BIT-1`; the width is `$clog2(CLKS_PER_BIT)`.
  - The tick is asserted when the count equals `CLKS_PER_BIT-1`, and the count then wraps to 0.
  - The timer is held at 0 in `IDLE`.
- `data_i` and `en_i` are ignored outside `IDLE`; changing them mid-frame has no effect.
- Reset, including mid-frame:
  - Immediately: state `IDLE`, `txd_o`=1, `ready_o`=1, timer and index 0.
  - The frame in progress is dropped; there is no partial completion.
  - `en_i` is ignored while `rst_i`=1.

## Timing
- Acceptance occurs at edge E0, where `ready_o`=1 and `en_i`=1.
- After E0, `ready_o`=0 and `txd_o`=0; the start bit begins.
- Bit k is driven on [E0+k·N, E0+(k+1)·N), with N=`CLKS_PER_BIT`:
  - k=0: start bit.
  - k=1..`DATA_AMOUNT`: data bits, LSB first.
  - k=`DATA_AMOUNT+1`: parity.
  - k=`DATA_AMOUNT+2`: stop.
- At edge E0+(`DATA_AMOUNT`+3)·N the block returns to `IDLE` and `ready_o` goes to 1.
  - The earliest next acceptance is the following edge.
  - With `en_i` held high, frames run back-to-back with exactly one idle-high cycle between them, which makes the stop bit effectively N+1 cycles.
- `ready_o` is low for exactly (`DATA_AMOUNT`+3)·N cycles per frame.
- No combinational path from inputs to outputs.

## Structure
- Shared package `uart_pkg` holds:
  - the `uart_state_t` enum (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`);
  - the function `clks_per_bit(clk_khz, bods)`, so the TX and RX halves use identical arithmetic.
- One natural sub-module, `uart_bit_timer`:
  - parameter `CLKS_PER_BIT`; inputs `clk_i`, `rst_i`, `run_i`; output `tick_o`;
  - `run_i`=0 clears the count.
- `uart_tx` contains the FSM, the shift register and the parity register.

## Test plan
Simulation parameters: `CLK_KHZ`=1000, `BODS`=100000, giving N=10.

- **Reset:** assert `rst_i` with `en_i`=1 → `txd_o`=1 and `ready_o`=1 throughout; no start bit after release until `en_i` is sampled in `IDLE`.
- **Word 0x72:** one-cycle `en_i` pulse with `data_i`=8'h72.
  - `txd_o` bit sequence 0, 0,1,0,0,1,1,1,0, parity 1, stop 1, each bit 10 cycles.
  - `ready_o` low for 110 cycles.
- **Word 0xA1:**
  - Data bits 1,0,0,0,0,1,0,1, parity 0.
  - `data_i` changed to 8'hFF at cycle 30 → no effect on the frame.
- **Back-to-back:** `en_i` held high; `data_i`=8'h08, then switched to 8'h7F during frame 1.
  - Frame 1 carries 8'h08 with parity 0.
  - Exactly one idle-high cycle, then frame 2 carries 8'h7F with parity 0.
- **Reset mid-frame:** pulse `rst_i` during data bit 4.
  - `txd_o`=1 in the same cycle, asynchronously.
  - A following request for 8'h08 sends a complete, correct frame.
- **Loopback:** `txd_o` drives the project UART receiver's `rxd_i`; send 8'h72 and 8'hA1 → `valid_data_o` pulses once per frame with `data_o` equal to the word sent.
